instr_exec_sequencer: RTL and testbench
=======================================

Name: instr_exec_sequencer

Overview:
- Sequences execution of a block of stored instructions from the 32-entry instruction register file through a shared ALU.
- For each entry it fetches the opcode and operands, dispatches them to the ALU over a valid/ready handshake, and writes the 64-bit result back into the same entry's result field.
- It sits between the test/control layer (start/done) and the instruction register file plus ALU.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_RSP before the instruction is abandoned; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- base_addr  in  5  first entry of the run
- count  in  6  number of entries, 0..32
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  5  read address
- rf_rd_opc  in  4  opcode_t, valid the cycle after rf_rd_en
- rf_rd_op_a/op_b/op_c  in  32 each  signed operands, same timing as rf_rd_opc
- alu_req_valid  out  1  ALU request valid
- alu_req_ready  in  1  ALU accepts the request
- alu_opc  out  4  opcode to the ALU
- alu_op_a/op_b/op_c  out  32 each  operands to the ALU
- alu_rsp_valid  in  1  ALU result valid
- alu_rsp_result  in  64  signed result_t
- rf_wr_en  out  1  result write strobe
- rf_wr_addr  out  5  result write address
- rf_wr_result  out  64  result written back
- exec_count  out  6  instructions written back in the current or last run
- err_count  out  6  instructions resolved by error in the current or last run

Behaviour:
Reset:
- On reset, the FSM goes to IDLE.
- All outputs are 0, including both counters and every address and data output.
- Reset asserted mid-run abandons the run immediately: no writeback and no done pulse.

State machine:
- IDLE: on start, latch base_addr into cur_addr and count into remaining; clear exec_count and err_count.
  - If count==0, go to DONE; otherwise go to FETCH.
- FETCH: rf_rd_en=1 and rf_rd_addr=cur_addr for exactly one cycle; go to WAIT_RD.
- WAIT_RD: capture the opcode and operands. Decode:
  - Opcode ZERO: result 0, go to WRITEBACK.
  - Opcode 8..15 (illegal): result 0, err_count+1, go to WRITEBACK.
  - DIV or MOD with op_b==0: result 0, err_count+1, go to WRITEBACK; the ALU is not dispatched.
  - Otherwise go to DISPATCH.
- DISPATCH: drive alu_req_valid=1 with the captured opc and operands, held stable until alu_req_ready.
  - On the cycle valid&&ready is high, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - On alu_rsp_valid, capture alu_rsp_result and go to WRITEBACK.
  - If the timeout counter reaches TIMEOUT_CYCLES first: result 0, err_count+1, go to WRITEBACK.
  - If rsp_valid arrives on the same cycle as the timeout, the response wins.
  - alu_rsp_valid is ignored in every other state.
- WRITEBACK: rf_wr_en=1, rf_wr_addr=cur_addr, rf_wr_result=result, for one cycle.
  - exec_count+1; remaining-1; cur_addr+1, wrapping modulo 32 (31 wraps to 0).
  - If the decremented remaining==0, go to DONE; else go to FETCH.
- DONE: done=1 for one cycle; go to IDLE.

Timing and sequencing rules:
- Minimum latency per ALU instruction is 5 cycles (FETCH, WAIT_RD, DISPATCH, WAIT_RSP, WRITEBACK), with ready and the response each taking one cycle.
- A locally resolved instruction takes 3 cycles.
- start is ignored while busy is high.
- start on the DONE cycle is ignored; start on the cycle after DONE is accepted.
- rf_rd_en, alu_req_valid and rf_wr_en are never high simultaneously.
- exec_count counts every writeback, including error writebacks.
- exec_count and err_count hold their values in IDLE until the next accepted start.
- A count of 32 starting at any base_addr visits all 32 entries exactly once.

Test Plan:
- Basic run: base=0, count=3, entries {ADD 5,7; SUB 3,10; MULT -4,6}, ALU ready and responding in 1 cycle → writes 12, -7, -24 to addresses 0, 1, 2; done pulses once; exec_count=3; err_count=0; each instruction takes 5 cycles.
- Wrap: base=30, count=4, all PASSA with op_a equal to the address → writes go to 30, 31, 0, 1 in that order; count=0 → done on the cycle after the start cycle with no rd/wr strobes.
- Local resolution: entries {DIV 9,0; opcode 4'hC; ZERO} → each result is 0; alu_req_valid never asserts; err_count=2; exec_count=3.
- Backpressure: alu_req_ready held low 7 cycles → opc and operands stable throughout; exactly one accepted request per instruction; response 20 cycles later is written correctly.
- Timeout: TIMEOUT_CYCLES=8, no response → result 0 written after 8 cycles in WAIT_RSP, err_count=1; a late rsp_valid afterwards is ignored. A second case drives rsp_valid on exactly the timeout cycle → the response value is written and err_count is unchanged.
- Reset mid-run: count=5, reset asserted while in WAIT_RSP of the 2nd instruction → all outputs 0 next cycle, no further writes, no done pulse; a fresh start afterwards runs normally. start pulsed while busy → no effect.

Source files
------------

// File: rtl/instr_exec_sequencer.sv
// rtl/instr_exec_sequencer.sv - runs a block of register-file instructions through a shared ALU
//
// Walks entries base_addr .. base_addr+count-1 (mod 32) of the instruction
// register file. Each entry is read, decoded, dispatched to the ALU over a
// valid/ready handshake unless it can be resolved locally, and its 64-bit
// result is written back to the same entry.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start               begin a run, sampled only in IDLE
//   base_addr, count    first entry and number of entries (0..32)
//   busy, done          busy outside IDLE, done one-cycle pulse at end of run
//   rf_rd_*             register-file read strobe/address, opcode and operands
//                       return the cycle after rf_rd_en
//   alu_req_*, alu_opc, alu_op_a/b/c   ALU request channel
//   alu_rsp_valid, alu_rsp_result      ALU response channel
//   rf_wr_*             result write-back strobe, address and data
//   exec_count          entries written back in the current or last run
//   err_count           entries resolved by error in the current or last run

module instr_exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  base_addr,
  input  logic [5:0]  count,
  output logic        busy,
  output logic        done,
  output logic        rf_rd_en,
  output logic [4:0]  rf_rd_addr,
  input  logic [3:0]  rf_rd_opc,
  input  logic [31:0] rf_rd_op_a,
  input  logic [31:0] rf_rd_op_b,
  input  logic [31:0] rf_rd_op_c,
  output logic        alu_req_valid,
  input  logic        alu_req_ready,
  output logic [3:0]  alu_opc,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [31:0] alu_op_c,
  input  logic        alu_rsp_valid,
  input  logic [63:0] alu_rsp_result,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [63:0] rf_wr_result,
  output logic [5:0]  exec_count,
  output logic [5:0]  err_count
);

  localparam logic [3:0] OPC_ZERO = 4'd0;
  localparam logic [3:0] OPC_DIV  = 4'd4;
  localparam logic [3:0] OPC_MOD  = 4'd5;
  // Last WAIT_RSP cycle index; the counter starts at 0 on the first cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_DISPATCH, S_WAIT_RSP, S_WRITEBACK, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cur_addr;
  logic [5:0]  remaining;
  logic [3:0]  opc_q;
  logic [31:0] op_a_q, op_b_q, op_c_q;
  logic [63:0] res_q;
  logic [7:0]  tmo_cnt;
  logic [5:0]  exec_q, err_q;

  logic local_res;
  logic local_err;
  logic tmo_hit;

  // Entries the sequencer resolves without the ALU: ZERO, the illegal upper
  // opcode half, and divide/modulo by zero. All but ZERO count as errors.
  always_comb begin
    local_res = 1'b0;
    local_err = 1'b0;
    if (rf_rd_opc == OPC_ZERO) begin
      local_res = 1'b1;
    end else if (rf_rd_opc[3]) begin
      local_res = 1'b1;
      local_err = 1'b1;
    end else if ((rf_rd_opc == OPC_DIV || rf_rd_opc == OPC_MOD) && rf_rd_op_b == 32'd0) begin
      local_res = 1'b1;
      local_err = 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    rf_rd_en      = 1'b0;
    alu_req_valid = 1'b0;
    rf_wr_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (count == 6'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rf_rd_en  = 1'b1;
        state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        state_nxt = local_res ? S_WRITEBACK : S_DISPATCH;
      end
      S_DISPATCH: begin
        alu_req_valid = 1'b1;
        if (alu_req_ready) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        // A response on the timeout cycle still takes this path; the
        // datapath gives it priority over the timeout.
        if (alu_rsp_valid || tmo_hit) state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_wr_en  = 1'b1;
        state_nxt = (remaining == 6'd1) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= 5'd0;
      remaining <= 6'd0;
      opc_q     <= 4'd0;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      op_c_q    <= 32'd0;
      res_q     <= 64'd0;
      tmo_cnt   <= 8'd0;
      exec_q    <= 6'd0;
      err_q     <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= count;
            exec_q    <= 6'd0;
            err_q     <= 6'd0;
          end
        end
        S_WAIT_RD: begin
          opc_q  <= rf_rd_opc;
          op_a_q <= rf_rd_op_a;
          op_b_q <= rf_rd_op_b;
          op_c_q <= rf_rd_op_c;
          if (local_res) res_q <= 64'd0;
          if (local_err) err_q <= err_q + 6'd1;
        end
        S_DISPATCH: begin
          tmo_cnt <= 8'd0;
        end
        S_WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (alu_rsp_valid) begin
            res_q <= alu_rsp_result;
          end else if (tmo_hit) begin
            res_q <= 64'd0;
            err_q <= err_q + 6'd1;
          end
        end
        S_WRITEBACK: begin
          exec_q    <= exec_q + 6'd1;
          remaining <= remaining - 6'd1;
          cur_addr  <= cur_addr + 5'd1;  // 5-bit add wraps 31 -> 0
        end
        default: ;
      endcase
    end
  end

  assign rf_rd_addr   = cur_addr;
  assign rf_wr_addr   = cur_addr;
  assign rf_wr_result = res_q;
  assign alu_opc      = opc_q;
  assign alu_op_a     = op_a_q;
  assign alu_op_b     = op_b_q;
  assign alu_op_c     = op_c_q;
  assign exec_count   = exec_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// tb/tb_instr_exec_sequencer.sv - directed self-checking bench for instr_exec_sequencer

module tb_instr_exec_sequencer;

  // Long enough for a 20-cycle response to land, short enough for the
  // timeout boundary to be exercised directly.
  localparam int TMO = 24;

  localparam logic [3:0] ZERO = 4'd0, ADD = 4'd1, SUB = 4'd2, MULT = 4'd3;
  localparam logic [3:0] DIV = 4'd4, PASSA = 4'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = 5'd0;
  logic [5:0]  count = 6'd0;
  logic        busy, done;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [3:0]  rf_rd_opc = 4'd0;
  logic [31:0] rf_rd_op_a = 32'd0, rf_rd_op_b = 32'd0, rf_rd_op_c = 32'd0;
  logic        alu_req_valid, alu_req_ready;
  logic [3:0]  alu_opc;
  logic [31:0] alu_op_a, alu_op_b, alu_op_c;
  logic        alu_rsp_valid = 1'b0;
  logic [63:0] alu_rsp_result = 64'd0;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_result;
  logic [5:0]  exec_count, err_count;

  instr_exec_sequencer #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_opc(rf_rd_opc), .rf_rd_op_a(rf_rd_op_a), .rf_rd_op_b(rf_rd_op_b),
    .rf_rd_op_c(rf_rd_op_c), .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
    .alu_opc(alu_opc), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_c(alu_op_c),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_result(alu_rsp_result),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_result(rf_wr_result),
    .exec_count(exec_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Register file contents
  logic [3:0]  m_opc [32];
  logic [31:0] m_a [32], m_b [32], m_c [32];

  task automatic set_ent(input int ad, input logic [3:0] o, input int a, input int b);
    m_opc[ad] = o;
    m_a[ad]   = 32'(a);
    m_b[ad]   = 32'(b);
    m_c[ad]   = 32'(ad);
  endtask

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_opc  <= m_opc[rf_rd_addr];
      rf_rd_op_a <= m_a[rf_rd_addr];
      rf_rd_op_b <= m_b[rf_rd_addr];
      rf_rd_op_c <= m_c[rf_rd_addr];
    end
  end

  // ALU stub: ready after ready_lat stalled cycles, response in WAIT_RSP cycle rsp_lat
  int ready_lat = 0;
  int rsp_lat = 1;
  bit rsp_en = 1'b1;
  int vcnt = 0;
  bit pend = 1'b0;
  int tmr = 0;
  logic [63:0] pend_data = 64'd0;

  function automatic logic [63:0] alu_fn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (o)
      ADD:   return sa + sb;
      SUB:   return sa - sb;
      MULT:  return sa * sb;
      PASSA: return sa;
      default: return 64'd0;
    endcase
  endfunction

  assign alu_req_ready = alu_req_valid && (vcnt >= ready_lat);

  always @(posedge clk) begin
    alu_rsp_valid <= 1'b0;
    if (reset) begin
      vcnt <= 0;
      pend <= 1'b0;
      tmr  <= 0;
    end else begin
      if (alu_req_valid && !alu_req_ready) vcnt <= vcnt + 1;
      else vcnt <= 0;
      if (alu_req_valid && alu_req_ready && rsp_en) begin
        if (rsp_lat <= 1) begin
          alu_rsp_valid  <= 1'b1;
          alu_rsp_result <= alu_fn(alu_opc, alu_op_a, alu_op_b);
        end else begin
          pend      <= 1'b1;
          tmr       <= rsp_lat - 1;
          pend_data <= alu_fn(alu_opc, alu_op_a, alu_op_b);
        end
      end else if (pend) begin
        if (tmr == 1) begin
          alu_rsp_valid  <= 1'b1;
          alu_rsp_result <= pend_data;
          pend           <= 1'b0;
        end else begin
          tmr <= tmr - 1;
        end
      end
    end
  end

  // Monitors, sampled on the falling edge
  int cyc = 0;
  int wr_n = 0;
  logic [4:0]  wr_a [64];
  logic [63:0] wr_d [64];
  int          wr_t [64];
  int rd_n = 0, done_n = 0, acc_n = 0, vld_n = 0, overlap_n = 0, unstable_n = 0;
  bit stall = 1'b0;
  logic [3:0]  s_opc;
  logic [31:0] s_a, s_b, s_c;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (rf_wr_en && wr_n < 64) begin
        wr_a[wr_n] <= rf_wr_addr;
        wr_d[wr_n] <= rf_wr_result;
        wr_t[wr_n] <= cyc;
        wr_n <= wr_n + 1;
      end
      if (rf_rd_en) rd_n <= rd_n + 1;
      if (done) done_n <= done_n + 1;
      if (alu_req_valid) vld_n <= vld_n + 1;
      if (alu_req_valid && alu_req_ready) acc_n <= acc_n + 1;
      if (32'(rf_rd_en) + 32'(alu_req_valid) + 32'(rf_wr_en) > 1) overlap_n <= overlap_n + 1;
      if (alu_req_valid && stall &&
          {alu_opc, alu_op_a, alu_op_b, alu_op_c} != {s_opc, s_a, s_b, s_c})
        unstable_n <= unstable_n + 1;
    end
    stall <= alu_req_valid && !alu_req_ready;
    s_opc <= alu_opc;
    s_a   <= alu_op_a;
    s_b   <= alu_op_b;
    s_c   <= alu_op_c;
  end

  // Start a run, optionally poke start again while busy, wait (bounded) for done.
  task automatic do_run(input logic [4:0] b, input logic [5:0] c, input int poke_at, output int n);
    @(negedge clk);
    base_addr = b;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 300) begin
      if (n == poke_at) begin
        base_addr = 5'd20;
        count = 6'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("run_done_seen", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_wr(input int idx, input logic [4:0] ad, input logic [63:0] d);
    if (idx < wr_n) begin
      check("wr_addr", 64'(wr_a[idx]), 64'(ad));
      check("wr_data", wr_d[idx], d);
    end else begin
      check("wr_missing", 64'(wr_n), 64'(idx + 1));
    end
  endtask

  int n, w0, r0, d0, a0, v0;

  initial begin
    for (int i = 0; i < 32; i++) set_ent(i, ZERO, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", {61'd0, rf_rd_en, alu_req_valid, rf_wr_en}, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", {54'd0, rf_rd_addr, rf_wr_addr}, 64'd0);
    check("rst_wdata", rf_wr_result, 64'd0);
    check("rst_alu", {alu_op_a, alu_op_b | alu_op_c | 32'(alu_opc)}, 64'd0);
    check("rst_cnts", {52'd0, exec_count, err_count}, 64'd0);
    reset = 1'b0;

    // Basic run: 12, -7, -24, five cycles apart
    set_ent(0, ADD, 5, 7);
    set_ent(1, SUB, 3, 10);
    set_ent(2, MULT, -4, 6);
    w0 = wr_n; d0 = done_n; a0 = acc_n;
    do_run(5'd0, 6'd3, 0, n);
    check("basic_cycles", 64'(n), 64'd16);
    check("basic_wr_n", 64'(wr_n - w0), 64'd3);
    chk_wr(w0, 5'd0, 64'd12);
    chk_wr(w0 + 1, 5'd1, -64'sd7);
    chk_wr(w0 + 2, 5'd2, -64'sd24);
    check("basic_spacing1", 64'(wr_t[w0 + 1] - wr_t[w0]), 64'd5);
    check("basic_spacing2", 64'(wr_t[w0 + 2] - wr_t[w0 + 1]), 64'd5);
    check("basic_done_n", 64'(done_n - d0), 64'd1);
    check("basic_acc_n", 64'(acc_n - a0), 64'd3);
    check("basic_exec", 64'(exec_count), 64'd3);
    check("basic_err", 64'(err_count), 64'd0);

    // Wrap 30,31,0,1
    for (int i = 0; i < 4; i++) set_ent((30 + i) % 32, PASSA, (30 + i) % 32, 0);
    w0 = wr_n;
    do_run(5'd30, 6'd4, 0, n);
    check("wrap_wr_n", 64'(wr_n - w0), 64'd4);
    chk_wr(w0, 5'd30, 64'd30);
    chk_wr(w0 + 1, 5'd31, 64'd31);
    chk_wr(w0 + 2, 5'd0, 64'd0);
    chk_wr(w0 + 3, 5'd1, 64'd1);
    check("wrap_exec", 64'(exec_count), 64'd4);

    // count == 0
    w0 = wr_n; r0 = rd_n; d0 = done_n;
    do_run(5'd7, 6'd0, 0, n);
    check("c0_cycles", 64'(n), 64'd1);
    check("c0_rd_n", 64'(rd_n - r0), 64'd0);
    check("c0_wr_n", 64'(wr_n - w0), 64'd0);
    check("c0_done_n", 64'(done_n - d0), 64'd1);
    check("c0_exec", 64'(exec_count), 64'd0);

    // Local resolution: DIV by zero, illegal, ZERO
    set_ent(12, DIV, 9, 0);
    set_ent(13, 4'hC, 1, 1);
    set_ent(14, ZERO, 3, 4);
    w0 = wr_n; v0 = vld_n;
    do_run(5'd12, 6'd3, 0, n);
    check("local_cycles", 64'(n), 64'd10);
    chk_wr(w0, 5'd12, 64'd0);
    chk_wr(w0 + 1, 5'd13, 64'd0);
    chk_wr(w0 + 2, 5'd14, 64'd0);
    check("local_no_req", 64'(vld_n - v0), 64'd0);
    check("local_err", 64'(err_count), 64'd2);
    check("local_exec", 64'(exec_count), 64'd3);

    // Backpressure 7 cycles, response 20 cycles after acceptance
    set_ent(5, ADD, 100, -1);
    ready_lat = 7; rsp_lat = 20;
    w0 = wr_n; v0 = vld_n; a0 = acc_n;
    do_run(5'd5, 6'd1, 0, n);
    check("bp_valid_cycles", 64'(vld_n - v0), 64'd8);
    check("bp_acc_n", 64'(acc_n - a0), 64'd1);
    check("bp_stable", 64'(unstable_n), 64'd0);
    chk_wr(w0, 5'd5, 64'd99);
    check("bp_err", 64'(err_count), 64'd0);
    ready_lat = 0;

    // Timeout with a response arriving well after the run is over
    set_ent(8, SUB, 50, 8);
    rsp_lat = 30;
    w0 = wr_n;
    do_run(5'd8, 6'd1, 0, n);
    check("tmo_cycles", 64'(n), 64'(TMO + 5));
    chk_wr(w0, 5'd8, 64'd0);
    check("tmo_err", 64'(err_count), 64'd1);
    repeat (10) @(negedge clk);
    check("tmo_late_wr_n", 64'(wr_n - w0), 64'd1);
    check("tmo_late_err", 64'(err_count), 64'd1);
    check("tmo_late_exec", 64'(exec_count), 64'd1);

    // Response on exactly the timeout cycle wins
    rsp_lat = TMO;
    w0 = wr_n;
    do_run(5'd8, 6'd1, 0, n);
    check("edge_cycles", 64'(n), 64'(TMO + 5));
    chk_wr(w0, 5'd8, 64'd42);
    check("edge_err", 64'(err_count), 64'd0);

    // Reset in WAIT_RSP of the second instruction
    for (int i = 16; i < 21; i++) set_ent(i, ADD, 1, 2);
    rsp_lat = 10;
    w0 = wr_n; d0 = done_n;
    @(negedge clk);
    base_addr = 5'd16; count = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_wr_before", 64'(wr_n - w0), 64'd1);
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_strobes", {61'd0, rf_rd_en, alu_req_valid, rf_wr_en}, 64'd0);
    check("mid_addr", {54'd0, rf_rd_addr, rf_wr_addr}, 64'd0);
    check("mid_data", rf_wr_result, 64'd0);
    check("mid_alu", {alu_op_a, alu_op_b}, 64'd0);
    check("mid_cnts", {52'd0, exec_count, err_count}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_no_wr", 64'(wr_n - w0), 64'd1);
    check("mid_no_done", 64'(done_n - d0), 64'd0);

    // Fresh run after reset, with a start poke while busy
    rsp_lat = 1;
    set_ent(0, ADD, 5, 7);
    w0 = wr_n; d0 = done_n;
    do_run(5'd0, 6'd1, 2, n);
    check("fresh_cycles", 64'(n), 64'd6);
    check("fresh_wr_n", 64'(wr_n - w0), 64'd1);
    chk_wr(w0, 5'd0, 64'd12);
    check("fresh_exec", 64'(exec_count), 64'd1);
    repeat (8) @(negedge clk);
    check("fresh_poke_ignored", {62'd0, busy, 1'b0} | 64'(done_n - d0), 64'd1);

    check("no_overlap", 64'(overlap_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
